// File: rtl/cpu_seq.sv
// Multi-cycle 16-bit-style CPU: request/ready handshake, IDLE/EXEC/MEM/WB sequencer,
// internal register file and synchronous RAM, registered result and status flags.
module cpu_seq #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        op,
  input  logic [REG_AW-1:0] op1,
  input  logic [REG_AW-1:0] op2,
  output logic [WIDTH-1:0]  Y,
  output logic              C,
  output logic              V,
  output logic              Z,
  output logic              done
);

  localparam int NREG  = 2**REG_AW;
  localparam int DEPTH = 2**MEM_AW;
  localparam int MSB   = WIDTH-1;

  localparam logic [3:0] OP_INC = 4'h0, OP_DEC = 4'h1, OP_SUB = 4'h2, OP_ADD = 4'h3,
                         OP_SHL = 4'h4, OP_STORE = 4'h5, OP_LOAD = 4'h6, OP_LAND = 4'h7,
                         OP_LOR = 4'h8, OP_AND = 4'h9, OP_OR = 4'ha, OP_XNOR = 4'hb,
                         OP_SHR = 4'hc, OP_MOV = 4'hd, OP_NOT = 4'he, OP_NOP = 4'hf;

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [REG_AW-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [WIDTH-1:0]    regs_q [NREG];
  logic [WIDTH-1:0]    regs_d [NREG];
  logic [WIDTH-1:0]    res_q, res_d;
  logic                c_res_q, c_res_d, v_res_q, v_res_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic                c_q, c_d, v_q, v_d, z_q, z_d;
  logic [WIDTH-1:0]    ram [DEPTH];
  logic [WIDTH-1:0]    rdata;

  logic                accept;
  logic [WIDTH-1:0]    a, b, x;
  logic [MEM_AW-1:0]   addr;
  logic [WIDTH:0]      add_full, sub_full;
  logic                add_v, sub_v;

  assign accept = instr_valid && instr_ready;
  assign a      = regs_q[op1_q];
  assign b      = regs_q[op2_q];
  assign addr   = b[MEM_AW-1:0];

  // INC/DEC share the adder/subtractor with a constant-one second operand.
  assign x        = (op_q == OP_INC || op_q == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign add_full = {1'b0, a} + {1'b0, x};
  assign sub_full = {1'b0, a} - {1'b0, x};
  assign add_v    = (a[MSB] == x[MSB]) && (add_full[MSB] != a[MSB]);
  assign sub_v    = (a[MSB] != x[MSB]) && (sub_full[MSB] != a[MSB]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      c_res_q <= 1'b0;
      v_res_q <= 1'b0;
      y_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= WIDTH'(i);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      c_res_q <= c_res_d;
      v_res_q <= v_res_d;
      y_q     <= y_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      regs_q  <= regs_d;
    end
  end

  // RAM is never cleared; a store caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state_q == EXEC && op_q == OP_STORE) ram[addr] <= a;
    rdata <= ram[addr];
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = (op_q == OP_LOAD) ? MEM : WB;
      MEM:     state_d = WB;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    instr_ready = (state_q == IDLE);
    done        = (state_q == WB);
  end

  always_comb begin
    op_d  = accept ? op  : op_q;
    op1_d = accept ? op1 : op1_q;
    op2_d = accept ? op2 : op2_q;
  end

  // Datapath: result and pending flags computed in EXEC, load data captured in MEM
  always_comb begin
    res_d   = res_q;
    c_res_d = c_res_q;
    v_res_d = v_res_q;
    if (state_q == EXEC) begin
      c_res_d = 1'b0;
      v_res_d = 1'b0;
      case (op_q)
        OP_INC, OP_ADD: begin res_d = add_full[MSB:0]; c_res_d = add_full[WIDTH]; v_res_d = add_v; end
        OP_DEC, OP_SUB: begin res_d = sub_full[MSB:0]; c_res_d = sub_full[WIDTH]; v_res_d = sub_v; end
        OP_SHL:   begin res_d = {a[MSB-1:0], 1'b0}; c_res_d = a[MSB]; end
        OP_SHR:   begin res_d = {1'b0, a[MSB:1]};   c_res_d = a[0]; end
        OP_STORE: res_d = a;
        OP_LAND:  res_d = {{(WIDTH-1){1'b0}}, (a != '0) && (b != '0)};
        OP_LOR:   res_d = {{(WIDTH-1){1'b0}}, (a != '0) || (b != '0)};
        OP_AND:   res_d = a & b;
        OP_OR:    res_d = a | b;
        OP_XNOR:  res_d = ~(a ^ b);
        OP_MOV:   res_d = b;
        OP_NOT:   res_d = ~a;
        default:  res_d = res_q;
      endcase
    end else if (state_q == MEM) begin
      res_d = rdata;
    end
  end

  // Retirement: architectural state only changes on the WB edge
  always_comb begin
    y_d    = y_q;
    c_d    = c_q;
    v_d    = v_q;
    z_d    = z_q;
    regs_d = regs_q;
    if (state_q == WB) begin
      case (op_q)
        OP_NOP: ;
        OP_STORE: begin
          y_d = res_q;
          z_d = (res_q == '0);
        end
        default: begin
          y_d = res_q;
          c_d = c_res_q;
          v_d = v_res_q;
          z_d = (res_q == '0);
          regs_d[op1_q] = res_q;
        end
      endcase
    end
  end

  assign Y = y_q;
  assign C = c_q;
  assign V = v_q;
  assign Z = z_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: directed scenarios plus random instruction
// streams checked against an arithmetic reference model of the architectural state.
module tb_cpu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  op = 4'hf;
  logic [2:0]  op1 = '0, op2 = '0;
  logic [15:0] Y;
  logic        C, V, Z, done;

  int errors = 0;
  int checks = 0;

  int m_regs [8];
  int m_mem  [1024];
  bit m_wr   [1024];
  int m_y;
  bit m_c, m_v, m_z;

  cpu_seq #(.WIDTH(16), .REG_AW(3), .MEM_AW(10)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .op1(op1), .op2(op2), .Y(Y), .C(C), .V(V), .Z(Z), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic bit ovf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = i;
    m_y = 0; m_c = 0; m_v = 0; m_z = 0;
  endtask

  // Architectural effect of one instruction, from the opcode table.
  task automatic model_step(input logic [3:0] o, input int ai, input int bi, output int lat);
    int a, b, r;
    bit c, v;
    a = m_regs[ai]; b = m_regs[bi];
    r = 0; c = 0; v = 0; lat = 2;
    case (o)
      4'h0: begin r = a + 1; c = r > 65535; v = ovf(sgn(a) + 1); end
      4'h1: begin r = a - 1; c = a < 1;     v = ovf(sgn(a) - 1); end
      4'h2: begin r = a - b; c = a < b;     v = ovf(sgn(a) - sgn(b)); end
      4'h3: begin r = a + b; c = r > 65535; v = ovf(sgn(a) + sgn(b)); end
      4'h4: begin r = a * 2; c = a >= 32768; end
      4'h6: begin r = m_mem[b % 1024]; lat = 3; end
      4'h7: r = (a != 0 && b != 0) ? 1 : 0;
      4'h8: r = (a != 0 || b != 0) ? 1 : 0;
      4'h9: r = a & b;
      4'ha: r = a | b;
      4'hb: r = ~(a ^ b);
      4'hc: begin r = a / 2; c = a % 2; end
      4'hd: r = b;
      4'he: r = ~a;
      default: ;
    endcase
    r = r & 16'hffff;
    if (o == 4'h5) begin
      m_mem[b % 1024] = a; m_wr[b % 1024] = 1;
      m_y = a; m_z = (a == 0);
    end else if (o != 4'hf) begin
      m_y = r; m_c = c; m_v = v; m_z = (r == 0);
      m_regs[ai] = r;
    end
  endtask

  task automatic check_state(input string name);
    checks++;
    if (Y !== 16'(m_y) || C !== m_c || V !== m_v || Z !== m_z) begin
      errors++;
      $display("FAIL %s: got Y=%h C=%b V=%b Z=%b, want Y=%h C=%b V=%b Z=%b",
               name, Y, C, V, Z, 16'(m_y), m_c, m_v, m_z);
    end
  endtask

  task automatic do_reset();
    instr_valid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic issue(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b);
    int exp_lat, lat, w;
    model_step(o, int'(a), int'(b), exp_lat);
    @(negedge clk);
    instr_valid = 1; op = o; op1 = a; op2 = b;
    w = 0;
    while (!instr_ready && w < 10) begin @(negedge clk); w++; end
    if (!instr_ready) begin
      errors++; checks++;
      $display("FAIL issue_ready_timeout: op=%h ready=%b want 1", o, instr_ready);
      instr_valid = 0;
      return;
    end
    @(posedge clk);
    #1 instr_valid = 0;
    lat = 1;
    do begin @(posedge clk); #1; lat++; end while (!done && lat < 8);
    checks++;
    if (lat !== exp_lat || done !== 1'b1) begin
      errors++;
      $display("FAIL latency op=%h: got %0d (done=%b), want %0d", o, lat, done, exp_lat);
    end
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready op=%h: got %b want 0", o, instr_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL retire_idle op=%h: got done=%b ready=%b want 0/1", o, done, instr_ready);
    end
    check_state($sformatf("retire op=%h r%0d r%0d", o, a, b));
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (Y !== 16'h0 || C !== 0 || V !== 0 || Z !== 0 || done !== 0 || instr_ready !== 1) begin
      errors++;
      $display("FAIL reset_outputs: got Y=%h C=%b V=%b Z=%b done=%b ready=%b want 0 0 0 0 0 1",
               Y, C, V, Z, done, instr_ready);
    end
    issue(4'hd, 3'd5, 3'd5);
    issue(4'hd, 3'd7, 3'd7);
  endtask

  task automatic test_add();
    do_reset();
    issue(4'h3, 3'd1, 3'd2);
    issue(4'hd, 3'd1, 3'd1);
  endtask

  task automatic test_arith_edges();
    do_reset();
    issue(4'hd, 3'd3, 3'd7);
    repeat (15) issue(4'h4, 3'd3, 3'd0);
    repeat (4) issue(4'h1, 3'd4, 3'd0);
    issue(4'h3, 3'd3, 3'd4);
    do_reset();
    issue(4'h2, 3'd0, 3'd1);
    issue(4'hd, 3'd2, 3'd0);
    issue(4'hc, 3'd2, 3'd0);
    issue(4'h0, 3'd2, 3'd0);
    issue(4'h0, 3'd0, 3'd0);
  endtask

  task automatic test_load_store();
    do_reset();
    issue(4'h5, 3'd5, 3'd3);
    issue(4'h6, 3'd2, 3'd3);
    issue(4'hd, 3'd2, 3'd2);
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(4'h5, 3'd1, 3'd4);
    @(negedge clk);
    instr_valid = 1; op = 4'h5; op1 = 3'd6; op2 = 3'd4;
    @(posedge clk);
    #1 instr_valid = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    checks++;
    if (Y !== 16'h0 || C !== 0 || V !== 0 || Z !== 0 || done !== 0 || instr_ready !== 1) begin
      errors++;
      $display("FAIL reset_mid_outputs: got Y=%h C=%b V=%b Z=%b done=%b ready=%b want 0 0 0 0 0 1",
               Y, C, V, Z, done, instr_ready);
    end
    issue(4'h6, 3'd1, 3'd4);
    issue(4'hd, 3'd6, 3'd6);
  endtask

  task automatic test_back_to_back();
    int acc, dn, k1, k2, lat, pre_y;
    bit pre_c, pre_v, pre_z;
    pre_y = m_y; pre_c = m_c; pre_v = m_v; pre_z = m_z;
    acc = 0; dn = 0; k1 = -1; k2 = -1;
    @(negedge clk);
    instr_valid = 1; op = 4'hf; op1 = 3'd3; op2 = 3'd5;
    for (int k = 0; k < 12; k++) begin
      if (instr_ready && instr_valid) begin
        acc++;
        if (acc == 1) k1 = k;
        else begin
          k2 = k;
          checks++;
          if (Y !== 16'(pre_y) || C !== pre_c || V !== pre_v || Z !== pre_z) begin
            errors++;
            $display("FAIL nop_hold: got Y=%h C=%b V=%b Z=%b want Y=%h C=%b V=%b Z=%b",
                     Y, C, V, Z, 16'(pre_y), pre_c, pre_v, pre_z);
          end
        end
      end
      if (done) dn++;
      @(posedge clk); #1;
      if (acc == 1) begin op = 4'h7; op1 = 3'd0; op2 = 3'd1; end
      if (acc >= 2) instr_valid = 0;
      @(negedge clk);
    end
    instr_valid = 0;
    model_step(4'hf, 3, 5, lat);
    model_step(4'h7, 0, 1, lat);
    checks++;
    if (acc !== 2 || dn !== 2 || (k2 - k1) !== 3) begin
      errors++;
      $display("FAIL back_to_back: got accepts=%0d dones=%0d gap=%0d want 2 2 3", acc, dn, k2 - k1);
    end
    check_state("back_to_back_land");
  endtask

  task automatic test_random();
    logic [3:0] o;
    logic [2:0] a, b;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      o = 4'($urandom_range(15, 0));
      a = 3'($urandom_range(7, 0));
      b = 3'($urandom_range(7, 0));
      if (o == 4'h6 && !m_wr[m_regs[b] % 1024]) o = 4'h5;
      issue(o, a, b);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin m_mem[i] = 0; m_wr[i] = 0; end
    model_reset();
    test_reset();
    test_add();
    test_arith_edges();
    test_load_store();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle 16-bit cpu.
- Adds a registered request/acknowledge handshake, a sequenced FSM for ALU, load and store, register writeback of ALU results, and registered status flags.
- Shares the cpu's 4-bit opcode map, with the TODO slots now defined.
- Sits between the instruction source/testbench and the register file and RAM, both of which are internal to this block.

Parameters:
- WIDTH, 16, datapath and register width in bits (>= 4).
- REG_AW, 3, register address width; register count = 2**REG_AW.
- MEM_AW, 10, RAM address width; RAM depth = 2**MEM_AW.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction request.
- instr_ready  out  1  block can accept an instruction.
- op  in  4  opcode.
- op1  in  REG_AW  register address A; also the destination register.
- op2  in  REG_AW  register address B.
- Y  out  WIDTH  registered result of the last completed instruction.
- C  out  1  carry/borrow flag (registered).
- V  out  1  signed overflow flag (registered).
- Z  out  1  zero flag (registered).
- done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-instruction included):
  - State goes to IDLE; Y=0, C=0, V=0, Z=0, done=0, instr_ready=1 in the cycle after the edge.
  - reg[i]=i for all i.
  - RAM contents are not cleared.
  - An instruction in flight is abandoned with no register or RAM write; a store in EXEC during reset is suppressed.
- Handshake: accept occurs when instr_valid & instr_ready at an edge; op/op1/op2 are latched. instr_ready=1 only in IDLE. Inputs are ignored in all other states.
- FSM states: IDLE, EXEC, MEM, WB.
  - IDLE -> EXEC on accept; otherwise stay in IDLE.
  - EXEC: read reg[op1] (A) and reg[op2] (B); compute the ALU result into an internal register.
    - Store: write RAM[B[MEM_AW-1:0]] = A this cycle.
    - Load: present address B[MEM_AW-1:0] to the synchronous RAM.
    - EXEC -> MEM for load; EXEC -> WB otherwise.
  - MEM: capture RAM read data; go to WB.
  - WB: done=1; update Y and flags; write reg[op1] when the opcode writes back; go to IDLE. instr_ready rises the next cycle.
- Latency, accept edge to done-high cycle: 2 cycles for ALU, store and NOP; 3 cycles for load. Throughput: one instruction per 3 cycles (ALU) or 4 cycles (load).
- Opcodes. "wb" means reg[op1] is written; "Y" means Y gets the result.
  - 0000 INC: A+1, wb.
  - 0001 DEC: A-1, wb.
  - 0010 SUB: A-B, wb.
  - 0011 ADD: A+B, wb.
  - 0100 SHL: A<<1, C = A[WIDTH-1], wb.
  - 0101 STORE: no wb; Y = A.
  - 0110 LOAD: reg[op1] = RAM data; Y = data.
  - 0111 LAND: (A!=0 && B!=0) zero-extended to WIDTH, wb.
  - 1000 LOR: (A!=0 || B!=0) zero-extended to WIDTH, wb.
  - 1001 AND: A&B, wb.
  - 1010 OR: A|B, wb.
  - 1011 XNOR: ~(A^B), wb.
  - 1100 SHR: A>>1 logical, C = A[0], wb.
  - 1101 MOV: B, wb.
  - 1110 NOT: ~A, wb.
  - 1111 NOP: no wb; Y, C, V, Z held.
- Flags, updated in WB:
  - ADD/INC: C = unsigned carry-out.
  - SUB/DEC: C = borrow (1 iff A < subtrahend, unsigned).
  - ADD/SUB/INC/DEC: V = signed overflow of the WIDTH-bit operation.
  - SHL/SHR: C as listed above; V=0.
  - All logic ops, MOV and LOAD: C=0, V=0.
  - STORE and NOP: C and V held.
  - Z = (Y==0) for every opcode except NOP, which holds Z.
- Arithmetic wraps modulo 2**WIDTH.
- When op1==op2, A and B are the same register value.
- RAM addressing uses B[MEM_AW-1:0]; upper bits of B are ignored.
- Load followed by store to the same address: the store overwrites; a later load returns the new value.
- Register writes occur only in WB; EXEC reads therefore always see results of prior retired instructions (no hazard forwarding needed).

Test Plan:
- Reset, then ADD op1=1 op2=2 -> done 2 cycles after accept; Y=3, reg[1]=3, C=0, V=0, Z=0; instr_ready low for 2 cycles.
- With WIDTH=16, MOV r3<-r7, SHL r3 x15 then DEC r4 x4, ADD r3,r4 -> operands 0x8000 + 0x0000 as needed; separately SUB with reg[0]=0, reg[1]=1 (SUB op1=0 op2=1) -> Y=0xFFFF, C=1, V=0, Z=0.
- INC on register holding 0x7FFF -> Y=0x8000, V=1, C=0; INC on 0xFFFF -> Y=0, C=1, Z=1.
- STORE op1=5 op2=3 (RAM[3]=5), then LOAD op1=2 op2=3 -> load done 3 cycles after accept; Y=5, reg[2]=5.
- Assert rst during EXEC of STORE op1=6 op2=4, then LOAD op1=1 op2=4 -> RAM[4] unchanged; after reset all flags 0, reg[i]=i, instr_ready=1.
- Hold instr_valid high continuously with back-to-back NOP then LAND op1=0 op2=1 -> NOP leaves Y/flags unchanged; LAND gives Y=0, Z=1; exactly one accept per IDLE visit.
